// File: rtl/encoder_rreq_multistream_arb_if.sv
// Request-side bundle for the multistream read-request scheduler: frame
// configuration, inFIFO space flags, AXI request handshake and response routing.
interface encoder_rreq_multistream_arb_if #(
   parameter int ADDR_WIDTH    = 32,
   parameter int NUM_STREAMS   = 2,
   parameter int REQ_CNT_WIDTH = 16
);
   localparam int ID_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   logic                                   begin_encoding;
   logic [NUM_STREAMS*ADDR_WIDTH-1:0]      stream_baddr;
   logic [NUM_STREAMS*REQ_CNT_WIDTH-1:0]   stream_num_reqs;
   logic [NUM_STREAMS-1:0]                 stream_has_space;
   logic                                   axi_m_can_accept_rreq;
   logic                                   rburst_done;
   logic                                   dram_rreq;
   logic [ADDR_WIDTH-1:0]                  dram_raddr;
   logic [ID_W-1:0]                        dram_rstream_id;
   logic                                   rsp_id_valid;
   logic [ID_W-1:0]                        rsp_stream_id;
   logic                                   busy;
   logic                                   frame_done;
   logic                                   id_underflow;

   modport master (
      input  begin_encoding, stream_baddr, stream_num_reqs, stream_has_space,
             axi_m_can_accept_rreq, rburst_done,
      output dram_rreq, dram_raddr, dram_rstream_id, rsp_id_valid, rsp_stream_id,
             busy, frame_done, id_underflow
   );

   modport slave (
      output begin_encoding, stream_baddr, stream_num_reqs, stream_has_space,
             axi_m_can_accept_rreq, rburst_done,
      input  dram_rreq, dram_raddr, dram_rstream_id, rsp_id_valid, rsp_stream_id,
             busy, frame_done, id_underflow
   );
endinterface

// File: rtl/encoder_rreq_multistream_arb.sv
// Round-robin DRAM read-request scheduler across NUM_STREAMS input streams.
// Grants are gated by inFIFO space and an outstanding-burst budget; an in-order
// stream-ID queue tells the response side which inFIFO owns each returning burst.
//
// state | meaning
// IDLE  | waiting for begin_encoding
// RUN   | issuing bursts until every stream has issued its count
// DRAIN | all bursts issued, waiting for outstanding bursts to return
// DONE  | one-cycle frame_done, then back to IDLE
module encoder_rreq_multistream_arb #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BURST_LEN       = 128,
   parameter int NUM_STREAMS     = 2,
   parameter int REQ_CNT_WIDTH   = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic                          axi_clk,
   input logic                          axi_resetn,
   encoder_rreq_multistream_arb_if.master bus
);
   localparam int ID_W  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int DEPTH = 1 << PTR_W;
   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
   localparam logic [CNT_W-1:0]      MAX_CNT     = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                   state, state_n;
   logic [ADDR_WIDTH-1:0]    baddr    [NUM_STREAMS];
   logic [REQ_CNT_WIDTH-1:0] num_reqs [NUM_STREAMS];
   logic [REQ_CNT_WIDTH-1:0] issued   [NUM_STREAMS];
   logic [ID_W-1:0]          rr_ptr;
   logic [CNT_W-1:0]         out_cnt, out_cnt_n;
   logic [ID_W-1:0]          id_mem   [DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic                     rreq, uf;
   logic [ADDR_WIDTH-1:0]    raddr, addr_n;
   logic [ID_W-1:0]          rid, gnt_id;
   logic                     start, grant, pop, all_done;

   assign start  = (state == IDLE) && bus.begin_encoding;
   // a response with nothing outstanding is dropped and only flags id_underflow
   assign pop    = bus.rburst_done && (out_cnt != '0);
   assign addr_n = baddr[gnt_id] + ADDR_WIDTH'(issued[gnt_id]) * BURST_BYTES;

   // completion detect and round-robin search starting at rr_ptr
   always_comb begin
      logic [ID_W-1:0] s;
      grant    = 1'b0;
      gnt_id   = '0;
      all_done = 1'b1;
      s        = '0;
      for (int i = 0; i < NUM_STREAMS; i++)
         if (issued[i] != num_reqs[i]) all_done = 1'b0;
      // rreq low keeps requests at least two cycles apart
      if (state == RUN && !rreq && bus.axi_m_can_accept_rreq && out_cnt < MAX_CNT) begin
         for (int k = 0; k < NUM_STREAMS; k++) begin
            s = ID_W'((int'(rr_ptr) + k) % NUM_STREAMS);
            if (!grant && issued[s] < num_reqs[s] && bus.stream_has_space[s]) begin
               grant  = 1'b1;
               gnt_id = s;
            end
         end
      end
   end

   // outstanding count: simultaneous push and pop cancel out
   always_comb begin
      out_cnt_n = out_cnt;
      case ({grant, pop})
         2'b10:   out_cnt_n = out_cnt + CNT_W'(1);
         2'b01:   out_cnt_n = out_cnt - CNT_W'(1);
         default: out_cnt_n = out_cnt;
      endcase
   end

   // next-state logic; DRAIN looks at the post-edge count so the final response lands in DONE
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.begin_encoding) state_n = RUN;
         RUN:     if (all_done) state_n = DRAIN;
         DRAIN:   if (out_cnt_n == '0) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) state <= IDLE;
      else             state <= state_n;
   end

   // frame configuration captured once at start
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         for (int i = 0; i < NUM_STREAMS; i++) begin
            baddr[i]    <= '0;
            num_reqs[i] <= '0;
         end
      end else if (start) begin
         for (int i = 0; i < NUM_STREAMS; i++) begin
            baddr[i]    <= bus.stream_baddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            num_reqs[i] <= bus.stream_num_reqs[i*REQ_CNT_WIDTH +: REQ_CNT_WIDTH];
         end
      end
   end

   // per-stream issue progress and next round-robin start point
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         for (int i = 0; i < NUM_STREAMS; i++) issued[i] <= '0;
         rr_ptr <= '0;
      end else if (start) begin
         for (int i = 0; i < NUM_STREAMS; i++) issued[i] <= '0;
         rr_ptr <= '0;
      end else if (grant) begin
         issued[gnt_id] <= issued[gnt_id] + REQ_CNT_WIDTH'(1);
         rr_ptr         <= (gnt_id == ID_W'(NUM_STREAMS - 1)) ? '0 : gnt_id + ID_W'(1);
      end
   end

   // registered request outputs; address and ID hold between requests
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         rreq  <= 1'b0;
         raddr <= '0;
         rid   <= '0;
      end else begin
         rreq <= grant;
         if (grant) begin
            raddr <= addr_n;
            rid   <= gnt_id;
         end
      end
   end

   // in-order stream-ID queue; its occupancy is the outstanding count
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         out_cnt <= '0;
         for (int d = 0; d < DEPTH; d++) id_mem[d] <= '0;
      end else begin
         if (grant) begin
            id_mem[wr_ptr] <= gnt_id;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         out_cnt <= out_cnt_n;
      end
   end

   // sticky underflow flag, cleared when a new frame starts
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         uf <= 1'b0;
      end else begin
         if (start) uf <= 1'b0;
         if (bus.rburst_done && out_cnt == '0) uf <= 1'b1;
      end
   end

   assign bus.dram_rreq       = rreq;
   assign bus.dram_raddr      = raddr;
   assign bus.dram_rstream_id = rid;
   assign bus.rsp_id_valid    = (out_cnt != '0);
   assign bus.rsp_stream_id   = id_mem[rd_ptr];
   assign bus.busy            = (state != IDLE);
   assign bus.frame_done      = (state == DONE);
   assign bus.id_underflow    = uf;
endmodule

// File: tb/tb_encoder_rreq_multistream_arb.sv
// Bench for the multistream read-request scheduler: directed scenarios plus
// randomized frames, every cycle compared against a queue-based reference model.
module tb_encoder_rreq_multistream_arb;
   localparam int NS   = 2;
   localparam int AW   = 32;
   localparam int RW   = 16;
   localparam int MAXO = 4;
   localparam logic [31:0] BB = 32'd512;

   typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   encoder_rreq_multistream_arb_if #(.ADDR_WIDTH(AW), .NUM_STREAMS(NS), .REQ_CNT_WIDTH(RW)) bus ();

   encoder_rreq_multistream_arb #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(32), .BURST_LEN(128), .NUM_STREAMS(NS),
      .REQ_CNT_WIDTH(RW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .axi_clk(clk), .axi_resetn(rst_n), .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0]   cfg_base [NS];
   int            cfg_num  [NS];
   logic [NS-1:0] space_v;
   logic          accept_v;
   bit            begin_v, force_pop, resp_en, rand_env;
   int            dly_min, dly_max, space_pct, accept_pct;

   mphase_t       m_phase;
   logic [31:0]   m_base [NS];
   int            m_num [NS];
   int            m_issued [NS];
   int            m_rr, m_id;
   bit            m_rreq, m_uf;
   logic [31:0]   m_raddr;
   int            idq[$];
   int            due[$];

   logic [31:0]   dut_addrs[$];
   int            dut_ids[$];
   int            last_rb_cyc, fd_cyc;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = M_IDLE;
      m_rreq  = 1'b0;
      m_uf    = 1'b0;
      m_raddr = '0;
      m_id    = 0;
      m_rr    = 0;
      idq.delete();
      due.delete();
      for (int s = 0; s < NS; s++) begin
         m_base[s] = '0; m_num[s] = 0; m_issued[s] = 0;
      end
   endtask

   // one clock: drive inputs, predict, clock, update the model, compare all outputs
   task automatic step();
      int g;
      bit all_done, rb;
      if (rand_env) begin
         for (int s = 0; s < NS; s++) space_v[s] = ($urandom_range(99) < space_pct);
         accept_v = ($urandom_range(99) < accept_pct);
      end
      rb = force_pop || (resp_en && due.size() > 0 && cyc >= due[0]);
      if (rb && due.size() > 0) void'(due.pop_front());
      if (rb) last_rb_cyc = cyc;
      bus.begin_encoding        = begin_v;
      bus.stream_has_space      = space_v;
      bus.axi_m_can_accept_rreq = accept_v;
      bus.rburst_done           = rb;
      for (int s = 0; s < NS; s++) begin
         bus.stream_baddr[s*AW +: AW]    = cfg_base[s];
         bus.stream_num_reqs[s*RW +: RW] = RW'(cfg_num[s]);
      end
      g = -1;
      all_done = 1'b1;
      for (int s = 0; s < NS; s++) if (m_issued[s] != m_num[s]) all_done = 1'b0;
      if (m_phase == M_RUN && !m_rreq && accept_v && idq.size() < MAXO)
         for (int k = 0; k < NS; k++) begin
            int s;
            s = (m_rr + k) % NS;
            if (g < 0 && m_issued[s] < m_num[s] && space_v[s]) g = s;
         end

      @(posedge clk); #1;
      cyc++;

      if (m_phase == M_IDLE && begin_v) begin
         for (int s = 0; s < NS; s++) begin
            m_base[s] = cfg_base[s]; m_num[s] = cfg_num[s]; m_issued[s] = 0;
         end
         m_rr = 0;
         m_uf = 1'b0;
      end
      m_rreq = (g >= 0);
      if (g >= 0) begin
         m_raddr = m_base[g] + 32'(m_issued[g]) * BB;
         m_id    = g;
         m_issued[g]++;
         m_rr    = (g + 1) % NS;
      end
      if (rb) begin
         if (idq.size() == 0) m_uf = 1'b1;
         else void'(idq.pop_front());
      end
      if (g >= 0) begin
         idq.push_back(g);
         due.push_back(cyc + $urandom_range(dly_max, dly_min));
      end
      case (m_phase)
         M_IDLE:  if (begin_v) m_phase = M_RUN;
         M_RUN:   if (all_done) m_phase = M_DRAIN;
         M_DRAIN: if (idq.size() == 0) m_phase = M_DONE;
         M_DONE:  m_phase = M_IDLE;
         default: m_phase = M_IDLE;
      endcase
      begin_v   = 1'b0;
      force_pop = 1'b0;

      check("dram_rreq", 64'(bus.dram_rreq), 64'(m_rreq));
      check("dram_raddr", 64'(bus.dram_raddr), 64'(m_raddr));
      check("dram_rstream_id", 64'(bus.dram_rstream_id), 64'(m_id));
      check("rsp_id_valid", 64'(bus.rsp_id_valid), 64'(idq.size() > 0));
      if (idq.size() > 0) check("rsp_stream_id", 64'(bus.rsp_stream_id), 64'(idq[0]));
      check("busy", 64'(bus.busy), 64'(m_phase != M_IDLE));
      check("frame_done", 64'(bus.frame_done), 64'(m_phase == M_DONE));
      check("id_underflow", 64'(bus.id_underflow), 64'(m_uf));
      if (bus.dram_rreq === 1'b1) begin
         dut_addrs.push_back(bus.dram_raddr);
         dut_ids.push_back(int'(bus.dram_rstream_id));
      end
      if (bus.frame_done === 1'b1) fd_cyc = cyc;
   endtask

   task automatic run_steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // start a frame and clock until the model is idle again; optionally pulse a
   // stray begin_encoding with scrambled config mid-frame
   task automatic run_frame(bit disturb);
      int n;
      begin_v = 1'b1;
      step();
      n = 0;
      while (m_phase != M_IDLE && n < 3000) begin
         if (disturb && n == 3) begin
            begin_v = 1'b1;
            for (int s = 0; s < NS; s++) begin
               cfg_base[s] = $urandom; cfg_num[s] = $urandom_range(9);
            end
         end
         step();
         n++;
      end
      check("frame_end_busy", 64'(bus.busy), 64'(0));
   endtask

   task automatic clear_logs();
      dut_addrs.delete();
      dut_ids.delete();
      fd_cyc = -1;
      last_rb_cyc = -1;
   endtask

   initial begin
      int cnt1, t0;
      logic [31:0] exp_rr [6];

      rand_env = 0; begin_v = 0; force_pop = 0; resp_en = 1;
      dly_min = 4; dly_max = 4; space_pct = 100; accept_pct = 100;
      space_v = '1; accept_v = 1'b1;
      for (int s = 0; s < NS; s++) begin cfg_base[s] = '0; cfg_num[s] = 0; end
      bus.begin_encoding = 0; bus.stream_baddr = '0; bus.stream_num_reqs = '0;
      bus.stream_has_space = '0; bus.axi_m_can_accept_rreq = 0; bus.rburst_done = 0;
      model_reset();
      clear_logs();

      #2;
      check("rst_rreq", 64'(bus.dram_rreq), 64'(0));
      check("rst_raddr", 64'(bus.dram_raddr), 64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_id_valid), 64'(0));
      check("rst_rsp_id", 64'(bus.rsp_stream_id), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_underflow", 64'(bus.id_underflow), 64'(0));
      #20 rst_n = 1'b1;
      run_steps(2);

      // round-robin and addressing
      cfg_base[0] = 32'h1000_0000; cfg_base[1] = 32'h2000_0000;
      cfg_num[0] = 3; cfg_num[1] = 3;
      clear_logs();
      run_frame(0);
      exp_rr[0] = 32'h1000_0000; exp_rr[1] = 32'h2000_0000;
      exp_rr[2] = 32'h1000_0200; exp_rr[3] = 32'h2000_0200;
      exp_rr[4] = 32'h1000_0400; exp_rr[5] = 32'h2000_0400;
      check("rr_count", 64'(dut_addrs.size()), 64'(6));
      for (int i = 0; i < 6; i++)
         if (i < dut_addrs.size()) check("rr_addr", 64'(dut_addrs[i]), 64'(exp_rr[i]));
      check("rr_done_latency", 64'(fd_cyc - last_rb_cyc), 64'(1));

      // space backpressure on stream 1
      dly_min = 2; dly_max = 6;
      clear_logs();
      space_v = 2'b01;
      begin_v = 1'b1;
      step();
      run_steps(20);
      cnt1 = 0;
      foreach (dut_ids[i]) if (dut_ids[i] == 1) cnt1++;
      check("bp_no_stream1", 64'(cnt1), 64'(0));
      check("bp_stream0_count", 64'(dut_ids.size()), 64'(3));
      space_v = 2'b11;
      begin_v = 1'b0;
      t0 = 0;
      while (m_phase != M_IDLE && t0 < 500) begin step(); t0++; end
      check("bp_total", 64'(dut_addrs.size()), 64'(6));
      if (dut_addrs.size() > 3) check("bp_s1_first_addr", 64'(dut_addrs[3]), 64'(32'h2000_0000));

      // outstanding limit
      clear_logs();
      resp_en = 0;
      begin_v = 1'b1;
      step();
      run_steps(20);
      check("os_stall_count", 64'(dut_addrs.size()), 64'(4));
      check("os_rsp_id_first", 64'(bus.rsp_stream_id), 64'(0));
      force_pop = 1'b1;
      step();
      check("os_rsp_id_second", 64'(bus.rsp_stream_id), 64'(1));
      run_steps(10);
      check("os_one_more", 64'(dut_addrs.size()), 64'(5));
      resp_en = 1;
      t0 = 0;
      while (m_phase != M_IDLE && t0 < 500) begin step(); t0++; end
      check("os_total", 64'(dut_addrs.size()), 64'(6));

      // empty frame
      clear_logs();
      cfg_num[0] = 0; cfg_num[1] = 0;
      t0 = cyc;
      run_frame(0);
      check("empty_no_req", 64'(dut_addrs.size()), 64'(0));
      check("empty_done_seen", 64'(fd_cyc >= 0), 64'(1));
      check("empty_done_within3", 64'(fd_cyc - t0 <= 3), 64'(1));

      // address wrap
      clear_logs();
      cfg_base[0] = 32'hFFFF_FE00; cfg_num[0] = 2; cfg_num[1] = 0;
      run_frame(0);
      check("wrap_count", 64'(dut_addrs.size()), 64'(2));
      if (dut_addrs.size() == 2) begin
         check("wrap_addr0", 64'(dut_addrs[0]), 64'(32'hFFFF_FE00));
         check("wrap_addr1", 64'(dut_addrs[1]), 64'(32'h0000_0000));
      end

      // reset mid-frame, stray response in IDLE, restart from the bases
      cfg_base[0] = 32'h1000_0000; cfg_base[1] = 32'h2000_0000;
      cfg_num[0] = 3; cfg_num[1] = 3;
      begin_v = 1'b1;
      step();
      run_steps(6);
      bus.rburst_done = 1'b0;
      bus.begin_encoding = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_rreq", 64'(bus.dram_rreq), 64'(0));
      check("arst_raddr", 64'(bus.dram_raddr), 64'(0));
      check("arst_rid", 64'(bus.dram_rstream_id), 64'(0));
      check("arst_rsp_valid", 64'(bus.rsp_id_valid), 64'(0));
      check("arst_rsp_id", 64'(bus.rsp_stream_id), 64'(0));
      check("arst_busy", 64'(bus.busy), 64'(0));
      check("arst_frame_done", 64'(bus.frame_done), 64'(0));
      model_reset();
      #7 rst_n = 1'b1;
      run_steps(2);
      force_pop = 1'b1;
      step();
      check("stray_underflow", 64'(bus.id_underflow), 64'(1));
      step();
      clear_logs();
      run_frame(0);
      check("restart_underflow_clr", 64'(bus.id_underflow), 64'(0));
      check("restart_count", 64'(dut_addrs.size()), 64'(6));
      if (dut_addrs.size() > 0) check("restart_first_addr", 64'(dut_addrs[0]), 64'(32'h1000_0000));

      // randomized frames with random space, accept, latency and stray begin pulses
      rand_env = 1; space_pct = 70; accept_pct = 80; dly_min = 1; dly_max = 12;
      for (int f = 0; f < 25; f++) begin
         for (int s = 0; s < NS; s++) begin
            cfg_base[s] = $urandom; cfg_num[s] = $urandom_range(6);
         end
         run_frame(f % 3 == 0);
         run_steps($urandom_range(3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
